// File: rtl/mag_timer.sv
// -----------------------------------------------------------------------------
// mag_timer
//   Countdown cook timer for the magnetron controller. Keypad digits are
//   shifted in as an MM:SS BCD time. While running, the time counts down one
//   second per TICK_DIV timebase strobes. It drives the four display digits,
//   a level timer_done flag (fed to mag_comb_logic) and a one-cycle
//   done_pulse when the countdown reaches 00:00.
//
// Parameters
//   TICK_DIV      tick strobes per one-second decrement (1..255)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   tick          one-cycle timebase strobe
//   key_valid     one-cycle strobe, key_digit holds a pressed key
//   key_digit     BCD key code (10..15 ignored)
//   clearn        clear request, high = clear
//   magnetron_on  registered magnetron enable from the downstream latch
//   min_tens/min_ones/sec_tens/sec_ones   BCD display digits
//   timer_done    high whenever all four digits are zero
//   done_pulse    one-cycle pulse when the countdown reaches 00:00
//   running       high while in RUN
//
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module mag_timer #(
   parameter int TICK_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       clearn,
   input  logic       magnetron_on,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       timer_done,
   output logic       done_pulse,
   output logic       running
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

   state_t      state_reg, state_next;
   // Packed as {min_tens, min_ones, sec_tens, sec_ones}; digit gi lives at [gi*4 +: 4].
   logic [15:0] digits_reg, digits_next;
   logic [7:0]  presc_reg, presc_next;
   logic        timer_done_reg, done_pulse_reg, running_reg;
   logic        done_pulse_next;

   logic        key_ok;
   logic [15:0] digits_shift;
   logic [15:0] digits_dec;
   logic [3:0]  digit_zero;
   logic [3:0]  borrow;

   assign key_ok       = key_valid && (key_digit <= 4'd9);
   assign digits_shift = {digits_reg[11:0], key_digit};

   // One-second BCD decrement. A digit borrows when every lower digit is zero;
   // the borrow is computed directly from the zero flags rather than chained.
   // sec_tens wraps to 5 (minute boundary), all other digits wrap to 9.
   // Entered sec_tens values above 5 simply count down from where they are.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dec
         localparam logic [3:0] WRAP = (gi == 1) ? 4'd5 : 4'd9;

         assign digit_zero[gi] = (digits_reg[gi*4 +: 4] == 4'd0);

         if (gi == 0) begin : g_lsd
            assign borrow[gi] = 1'b1;
         end else begin : g_upper
            assign borrow[gi] = &digit_zero[gi-1:0];
         end

         assign digits_dec[gi*4 +: 4] = !borrow[gi]     ? digits_reg[gi*4 +: 4] :
                                        digit_zero[gi]  ? WRAP :
                                                          digits_reg[gi*4 +: 4] - 4'd1;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         digits_reg     <= 16'h0000;
         presc_reg      <= 8'd0;
         timer_done_reg <= 1'b1;
         done_pulse_reg <= 1'b0;
         running_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         digits_reg     <= digits_next;
         presc_reg      <= presc_next;
         timer_done_reg <= (digits_next == 16'h0000);
         done_pulse_reg <= done_pulse_next;
         running_reg    <= (state_next == RUN);
      end
   end

   always_comb begin
      state_next      = state_reg;
      digits_next     = digits_reg;
      presc_next      = presc_reg;
      done_pulse_next = 1'b0;

      if (clearn) begin
         state_next  = IDLE;
         digits_next = 16'h0000;
         presc_next  = 8'd0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               // magnetron_on is ignored here: timer_done=1 keeps the
               // downstream latch from setting.
               if (key_ok) begin
                  digits_next = digits_shift;
                  if (digits_shift != 16'h0000) begin
                     state_next = ENTRY;
                  end
               end
            end

            ENTRY: begin
               if (key_ok) begin
                  digits_next = digits_shift;
               end
               if (magnetron_on) begin
                  state_next = RUN;
                  presc_next = 8'd0;
               end
            end

            RUN: begin
               // A tick sampled together with the falling magnetron_on is
               // still honoured; the move to PAUSE follows it.
               if (tick) begin
                  if (presc_reg == PRESC_LAST) begin
                     presc_next = 8'd0;
                     if (digits_reg == 16'h0000) begin
                        // Only reachable if an entry was shifted back to zero;
                        // finish quietly instead of wrapping to 99:59.
                        state_next = DONE;
                     end else begin
                        digits_next = digits_dec;
                        if (digits_dec == 16'h0000) begin
                           state_next      = DONE;
                           done_pulse_next = 1'b1;
                        end
                     end
                  end else begin
                     presc_next = presc_reg + 8'd1;
                  end
               end
               if (state_next == RUN && !magnetron_on) begin
                  state_next = PAUSE;
               end
            end

            PAUSE: begin
               // Prescaler is held so the partial second resumes where it stopped.
               if (magnetron_on) begin
                  state_next = RUN;
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign min_tens   = digits_reg[15:12];
   assign min_ones   = digits_reg[11:8];
   assign sec_tens   = digits_reg[7:4];
   assign sec_ones   = digits_reg[3:0];
   assign timer_done = timer_done_reg;
   assign done_pulse = done_pulse_reg;
   assign running    = running_reg;

endmodule

// File: tb/tb_mag_timer.sv
// -----------------------------------------------------------------------------
// tb_mag_timer
//   Self-checking bench for mag_timer. Two instances share the stimulus: u1
//   with TICK_DIV=1 and u4 with TICK_DIV=4 (prescaler pause/resume case).
//   Inputs change on the falling edge; outputs are checked 1 ns after the
//   rising edge that samples them.
// -----------------------------------------------------------------------------
module tb_mag_timer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tick = 1'b0;
   logic key_valid = 1'b0;
   logic [3:0] key_digit = 4'd0;
   logic clearn = 1'b0;
   logic magnetron_on = 1'b0;

   logic [3:0] mt1, mo1, st1, so1;
   logic       td1, dp1, run1;
   logic [3:0] mt4, mo4, st4, so4;
   logic       td4, dp4, run4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mag_timer #(.TICK_DIV(1)) u1 (
      .clk(clk), .rst(rst), .tick(tick), .key_valid(key_valid), .key_digit(key_digit),
      .clearn(clearn), .magnetron_on(magnetron_on),
      .min_tens(mt1), .min_ones(mo1), .sec_tens(st1), .sec_ones(so1),
      .timer_done(td1), .done_pulse(dp1), .running(run1)
   );

   mag_timer #(.TICK_DIV(4)) u4 (
      .clk(clk), .rst(rst), .tick(tick), .key_valid(key_valid), .key_digit(key_digit),
      .clearn(clearn), .magnetron_on(magnetron_on),
      .min_tens(mt4), .min_ones(mo4), .sec_tens(st4), .sec_ones(so4),
      .timer_done(td4), .done_pulse(dp4), .running(run4)
   );

   typedef struct {
      logic       kv;
      logic [3:0] kd;
      logic       clr;
      logic       mag;
      logic       tk;
      logic [15:0] exp_digits;
      logic       exp_td;
      logic       exp_dp;
      logic       exp_run;
   } vec_t;

   vec_t vecs[22];

   // Compare one instance's outputs against the expected digits/flags.
   task automatic check(input string name, input bit use4, input logic [15:0] ed,
                        input logic etd, input logic edp, input logic erun);
      logic [18:0] got, expv;
      if (use4) got = {mt4, mo4, st4, so4, td4, dp4, run4};
      else      got = {mt1, mo1, st1, so1, td1, dp1, run1};
      expv = {ed, etd, edp, erun};
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got digits=%h done=%b pulse=%b run=%b, expected digits=%h done=%b pulse=%b run=%b",
                  name, got[18:3], got[2], got[1], got[0], ed, etd, edp, erun);
      end else begin
         $display("ok   %s: digits=%h done=%b pulse=%b run=%b", name, got[18:3], got[2], got[1], got[0]);
      end
   endtask

   task automatic apply(input logic kv, input logic [3:0] kd, input logic clr,
                        input logic mag, input logic tk);
      @(negedge clk);
      key_valid    = kv;
      key_digit    = kd;
      clearn       = clr;
      magnetron_on = mag;
      tick         = tk;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      key_valid = 1'b0; key_digit = 4'd0; clearn = 1'b0; magnetron_on = 1'b0; tick = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      //           kv  kd     clr  mag  tk   digits    td   dp   run
      vecs[0]  = '{1'b1, 4'd1,  1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 16'h0013, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 16'h0130, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 16'h0130, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 16'h0130, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 16'h0129, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 4'd5,  1'b0, 1'b1, 1'b1, 16'h0128, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 16'h0128, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 16'h0128, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 16'h0128, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 16'h0128, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 16'h0127, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 16'h0127, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1};
      vecs[17] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1};
      vecs[18] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
      vecs[19] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
      vecs[20] = '{1'b1, 4'd4,  1'b0, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b1};

      // Reset state
      rst = 1'b1;
      #12;
      check("reset_state", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      do_reset();

      // Table: entry, run, pause, key/tick collision, clear, 00:02 countdown
      for (int i = 0; i < 22; i++) begin
         apply(vecs[i].kv, vecs[i].kd, vecs[i].clr, vecs[i].mag, vecs[i].tk);
         check($sformatf("vec%0d", i), 1'b0, vecs[i].exp_digits, vecs[i].exp_td,
               vecs[i].exp_dp, vecs[i].exp_run);
      end

      // Borrow chain 10:00 -> 09:59
      do_reset();
      apply(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
      apply(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      apply(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      apply(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      check("load_1000", 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      check("borrow_1000", 1'b0, 16'h0959, 1'b0, 1'b0, 1'b1);

      // Seconds tens above 5: 00:90 -> 00:89
      do_reset();
      apply(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
      apply(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      check("dec_0090", 1'b0, 16'h0089, 1'b0, 1'b0, 1'b1);

      // Pause/resume with TICK_DIV=4: prescaler held across the pause
      do_reset();
      apply(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      check("div4_two_ticks", 1'b1, 16'h0005, 1'b0, 1'b0, 1'b1);
      apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      check("div4_paused", 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) apply(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      check("div4_ticks_in_pause", 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      check("div4_resume_tick1", 1'b1, 16'h0005, 1'b0, 1'b0, 1'b1);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      check("div4_resume_tick2", 1'b1, 16'h0004, 1'b0, 1'b0, 1'b1);

      // Clear mid-RUN at 03:17
      do_reset();
      apply(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
      apply(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
      apply(1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      check("run_0317", 1'b0, 16'h0317, 1'b0, 1'b0, 1'b1);
      apply(1'b1, 4'd6, 1'b1, 1'b1, 1'b1);
      check("clear_0317", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      check("after_clear_idle", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

      // Async reset between edges while running
      do_reset();
      apply(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      apply(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      check("pre_async", 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      check("async_rst_div4", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
